// File: rtl/tone_gen_pkg.sv
// Shared constants for the tone-generator datapath and its parameter write scheduler.
package tone_gen_pkg;

    localparam int COUNT_WIDTH = 10;
    localparam int ADDR_WIDTH  = 6;
    localparam int DATA_WIDTH  = 16;

    // Parameter address map seen by the datapath
    localparam logic [5:0] PHASE_INCR_BASE = 6'h00;
    localparam logic [5:0] VOLUME_BASE     = 6'h04;
    localparam logic [5:0] WAVE_TYPE_BASE  = 6'h08;
    localparam logic [5:0] WAVE_MEM_BASE   = 6'h20;

    // master_id value during which a sample is being computed
    localparam logic [5:0] COMPUTE_ID = 6'h00;

    // Write-port requesters, also used as the round-robin pointer value
    typedef enum logic {
        SRC_HOST = 1'b0,
        SRC_ENV  = 1'b1
    } src_e;

endpackage

// File: rtl/param_fifo.sv
// Synchronous FIFO holding {addr, data} host writes until the write window opens.
module param_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_q];

    // Pointers and occupancy; push and pop in one cycle leave occupancy unchanged
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once counted as valid
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/param_write_scheduler.sv
// Master sequencing counter plus the datapath parameter write port, shared by a
// host FIFO and an envelope holding register; writes land only outside the compute window.
module param_write_scheduler
    import tone_gen_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = COUNT_WIDTH,
    parameter int ADDR_W     = ADDR_WIDTH,
    parameter int DATA_W     = DATA_WIDTH
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              run_in,
    input  logic              host_valid_in,
    input  logic [ADDR_W-1:0] host_addr_in,
    input  logic [DATA_W-1:0] host_data_in,
    output logic              host_ready_out,
    input  logic              env_valid_in,
    input  logic [ADDR_W-1:0] env_addr_in,
    input  logic [DATA_W-1:0] env_data_in,
    output logic              env_ready_out,
    output logic [CNT_W-1:0]  master_count_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out
);

    localparam logic [CNT_W-5:0] IDLE_ID = (CNT_W-4)'(COMPUTE_ID);

    logic [CNT_W-1:0]  count_q, count_d;
    logic              env_pend_q, env_pend_d;
    logic [ADDR_W-1:0] env_addr_q, env_addr_d;
    logic [DATA_W-1:0] env_data_q, env_data_d;
    src_e              ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic                     fifo_full, fifo_empty, host_push;
    logic [ADDR_W+DATA_W-1:0] fifo_dout;
    logic                     win_open, grant_host, grant_env, env_accept;

    assign count_d        = count_q + CNT_W'(run_in);
    // Judge the window on the count that will be visible alongside the strobe
    assign win_open       = (count_d[CNT_W-1:4] != IDLE_ID);
    assign host_ready_out = ~fifo_full;
    assign env_ready_out  = ~env_pend_q;
    assign host_push      = host_valid_in & ~fifo_full;
    assign env_accept     = env_valid_in & ~env_pend_q;

    param_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk_i   (clk_in),
        .reset_i (reset_in),
        .push_i  (host_push),
        .din_i   ({host_addr_in, host_data_in}),
        .pop_i   (grant_host),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Round-robin arbitration: the pointer always moves away from whoever was granted
    always_comb begin
        grant_host = 1'b0;
        grant_env  = 1'b0;
        ptr_d      = ptr_q;
        if (win_open) begin
            if (!fifo_empty && env_pend_q) begin
                if (ptr_q == SRC_HOST) grant_host = 1'b1;
                else                   grant_env  = 1'b1;
            end else if (!fifo_empty) begin
                grant_host = 1'b1;
            end else if (env_pend_q) begin
                grant_env = 1'b1;
            end
        end
        if (grant_host)     ptr_d = SRC_ENV;
        else if (grant_env) ptr_d = SRC_HOST;
    end

    // Envelope holding register and output port next state
    always_comb begin
        env_pend_d = env_pend_q;
        env_addr_d = env_addr_q;
        env_data_d = env_data_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        if (env_accept) begin
            env_pend_d = 1'b1;
            env_addr_d = env_addr_in;
            env_data_d = env_data_in;
        end else if (grant_env) begin
            env_pend_d = 1'b0;
        end
        if (grant_host) begin
            {addr_d, data_d} = fifo_dout;
            valid_d          = 1'b1;
        end else if (grant_env) begin
            addr_d  = env_addr_q;
            data_d  = env_data_q;
            valid_d = 1'b1;
        end
    end

    // State registers; reset discards any pending envelope write
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            count_q    <= '0;
            env_pend_q <= 1'b0;
            env_addr_q <= '0;
            env_data_q <= '0;
            ptr_q      <= SRC_HOST;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            env_pend_q <= env_pend_d;
            env_addr_q <= env_addr_d;
            env_data_q <= env_data_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign master_count_out = count_q;
    assign addr_out         = addr_q;
    assign data_out         = data_q;
    assign data_valid_out   = valid_q;

endmodule

// File: tb/tb_param_write_scheduler.sv
// Bench for param_write_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_param_write_scheduler;
    import tone_gen_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1, run = 1'b0, hv = 1'b0, ev = 1'b0;
    logic [5:0]  ha = '0, ea = '0;
    logic [15:0] hd = '0, ed = '0;
    logic        host_ready_out, env_ready_out, data_valid_out;
    logic [9:0]  master_count_out;
    logic [5:0]  addr_out;
    logic [15:0] data_out;

    param_write_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_in           (clk),
        .reset_in         (rst),
        .run_in           (run),
        .host_valid_in    (hv),
        .host_addr_in     (ha),
        .host_data_in     (hd),
        .host_ready_out   (host_ready_out),
        .env_valid_in     (ev),
        .env_addr_in      (ea),
        .env_data_in      (ed),
        .env_ready_out    (env_ready_out),
        .master_count_out (master_count_out),
        .addr_out         (addr_out),
        .data_out         (data_out),
        .data_valid_out   (data_valid_out)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0, strobe_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: counter as an integer mod 1024, host FIFO as a queue
    int          m_count = 0;
    logic [21:0] m_q[$];
    bit          m_env_pend = 0, m_ptr_env = 0, m_valid = 0;
    logic [21:0] m_env_w = '0;
    logic [5:0]  m_addr = '0;
    logic [15:0] m_data = '0;

    task automatic model_step();
        int nc;
        bit ok, gh, ge, hacc, eacc;
        if (rst) begin
            m_count = 0; m_q.delete(); m_env_pend = 0; m_ptr_env = 0;
            m_addr = '0; m_data = '0; m_valid = 0;
        end else begin
            nc   = (m_count + (run ? 1 : 0)) % 1024;
            ok   = (nc / 16) != 0;
            hacc = hv && (m_q.size() < DEPTH);
            eacc = ev && !m_env_pend;
            gh = 0; ge = 0;
            if (ok) begin
                if (m_q.size() > 0 && m_env_pend) begin
                    if (m_ptr_env) ge = 1; else gh = 1;
                end else if (m_q.size() > 0) gh = 1;
                else if (m_env_pend) ge = 1;
            end
            m_valid = gh || ge;
            if (gh) begin {m_addr, m_data} = m_q.pop_front(); m_ptr_env = 1; end
            if (ge) begin {m_addr, m_data} = m_env_w; m_env_pend = 0; m_ptr_env = 0; end
            if (hacc) m_q.push_back({ha, hd});
            if (eacc) begin m_env_pend = 1; m_env_w = {ea, ed}; end
            m_count = nc;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle, on the falling edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_count", 32'(master_count_out), 32'(m_count));
            chk("m_valid", 32'(data_valid_out), 32'(m_valid));
            chk("m_addr", 32'(addr_out), 32'(m_addr));
            chk("m_data", 32'(data_out), 32'(m_data));
            chk("m_host_ready", 32'(host_ready_out), 32'(m_q.size() < DEPTH));
            chk("m_env_ready", 32'(env_ready_out), 32'(!m_env_pend));
            if (data_valid_out) strobe_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to(int target);
        int n = 0;
        while (32'(master_count_out) != 32'(target) && n < 2000) begin
            tick();
            n++;
        end
        chk("run_to", 32'(master_count_out), 32'(target));
    endtask

    task automatic wait_valid(int budget);
        int n = 0;
        while (!data_valid_out && n < budget) begin
            tick();
            n++;
        end
        chk("strobe_seen", 32'(data_valid_out), 32'd1);
    endtask

    task automatic expect_strobe(string name, int cnt, int a, int d);
        chk({name, "_valid"}, 32'(data_valid_out), 32'd1);
        chk({name, "_count"}, 32'(master_count_out), 32'(cnt));
        chk({name, "_addr"}, 32'(addr_out), 32'(a));
        chk({name, "_data"}, 32'(data_out), 32'(d));
    endtask

    int s;

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_count", 32'(master_count_out), 32'd0);
        chk("rst_valid", 32'(data_valid_out), 32'd0);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_hready", 32'(host_ready_out), 32'd1);
        chk("rst_eready", 32'(env_ready_out), 32'd1);

        // Free-running counter and wrap, then hold
        rst = 1'b0; run = 1'b1;
        repeat (1023) tick();
        chk("cnt_1023", 32'(master_count_out), 32'd1023);
        tick();
        chk("cnt_wrap", 32'(master_count_out), 32'd0);
        repeat (76) tick();
        chk("cnt_76", 32'(master_count_out), 32'd76);
        run = 1'b0;
        repeat (5) tick();
        chk("cnt_hold", 32'(master_count_out), 32'd76);
        chk("no_strobes", 32'(strobe_cnt), 32'd0);

        // Single host write, two-cycle latency
        run = 1'b1;
        run_to(100);
        hv = 1'b1; ha = 6'h01; hd = 16'h1234;
        tick();
        hv = 1'b0;
        chk("lat_101_valid", 32'(data_valid_out), 32'd0);
        tick();
        expect_strobe("lat", 102, 'h01, 'h1234);
        tick();
        chk("lat_pulse_len", 32'(data_valid_out), 32'd0);

        // Window edge: 1020 strobes at 1022; 1022 strobes at 16
        run_to(1020);
        hv = 1'b1; ha = 6'h05; hd = 16'hAAAA;
        tick();
        hv = 1'b0;
        tick();
        expect_strobe("edge1022", 1022, 'h05, 'hAAAA);
        hv = 1'b1; ha = 6'h09; hd = 16'hBBBB;
        tick();
        hv = 1'b0;
        s = strobe_cnt;
        wait_valid(40);
        expect_strobe("edge16", 16, 'h09, 'hBBBB);
        chk("blocked_no_strobe", 32'(strobe_cnt), 32'(s));

        // FIFO fill while blocked with the counter stopped at 0
        run_to(0);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hv = 1'b1; ha = 6'(6'h10 + i); hd = 16'(16'h5000 + i);
            chk($sformatf("fill_ready%0d", i), 32'(host_ready_out), (i == 4) ? 32'd0 : 32'd1);
            tick();
        end
        hv = 1'b0;
        repeat (5) tick();
        chk("stall_valid", 32'(data_valid_out), 32'd0);
        chk("stall_count", 32'(master_count_out), 32'd0);
        run = 1'b1;
        wait_valid(40);
        for (int i = 0; i < 4; i++) begin
            expect_strobe($sformatf("drain%0d", i), 16 + i, 'h10 + i, 'h5000 + i);
            tick();
        end
        chk("drain_end", 32'(data_valid_out), 32'd0);

        // Lone envelope write; its grant also hands the pointer back to host
        run_to(150);
        ev = 1'b1; ea = VOLUME_BASE; ed = 16'h0777;
        tick();
        ev = 1'b0;
        chk("env_busy", 32'(env_ready_out), 32'd0);
        tick();
        expect_strobe("env_lone", 152, 'h04, 'h0777);
        chk("env_ready_back", 32'(env_ready_out), 32'd1);

        // Contention at count 200: host, env, host, env, host
        run_to(199);
        hv = 1'b1; ha = PHASE_INCR_BASE; hd = 16'hA000;
        ev = 1'b1; ea = VOLUME_BASE;     ed = 16'hE000;
        tick();
        chk("rr_200_idle", 32'(data_valid_out), 32'd0);
        ha = WAVE_TYPE_BASE; hd = 16'hA001; ev = 1'b0;
        tick();
        chk("rr_env_wait", 32'(env_ready_out), 32'd0);
        expect_strobe("rr_h0", 201, 'h00, 'hA000);
        ha = WAVE_MEM_BASE; hd = 16'hA002;
        tick();
        chk("rr_env_free", 32'(env_ready_out), 32'd1);
        expect_strobe("rr_e0", 202, 'h04, 'hE000);
        hv = 1'b0;
        ev = 1'b1; ea = 6'h05; ed = 16'hE001;
        tick();
        ev = 1'b0;
        expect_strobe("rr_h1", 203, 'h08, 'hA001);
        tick();
        expect_strobe("rr_e1", 204, 'h05, 'hE001);
        tick();
        expect_strobe("rr_h2", 205, 'h20, 'hA002);
        tick();
        chk("rr_end", 32'(data_valid_out), 32'd0);

        // Reset discards queued host writes and a pending envelope write
        run_to(0);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hv = 1'b1; ha = 6'(6'h30 + i); hd = 16'(16'hC000 + i);
            ev = (i == 0); ea = 6'h07; ed = 16'hD000;
            tick();
        end
        hv = 1'b0; ev = 1'b0;
        chk("pre_rst_eready", 32'(env_ready_out), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_hready", 32'(host_ready_out), 32'd1);
        chk("post_rst_eready", 32'(env_ready_out), 32'd1);
        chk("post_rst_valid", 32'(data_valid_out), 32'd0);
        chk("post_rst_count", 32'(master_count_out), 32'd0);
        s = strobe_cnt;
        run = 1'b1;
        repeat (60) tick();
        chk("post_rst_no_strobe", 32'(strobe_cnt), 32'(s));
        chk("post_rst_count60", 32'(master_count_out), 32'd60);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/param_write_scheduler.md
Name: param_write_scheduler

Overview:
Owns the 10-bit master sequencing counter that drives the tone-generator datapath. It also owns the datapath's single parameter write port (addr/data/valid).
Two requesters share that port: the host register interface, buffered in a small FIFO, and the envelope engine, through a single holding register.
Writes are released only outside the compute window (master_id == 0), so phase_incr, volume and wave_type never change while a sample is being computed.

Parameters:
FIFO_DEPTH, 4, host write FIFO entries (power of 2, >= 2)
COUNT_WIDTH, 10, master counter width; master_id = count[COUNT_WIDTH-1:4]
ADDR_WIDTH, 6, parameter address width
DATA_WIDTH, 16, parameter data width

Ports:
clk_in  input  1  clock; all state updates on the rising edge
reset_in  input  1  synchronous, active-high reset
run_in  input  1  counter advances when 1, holds when 0
host_valid_in  input  1  host write request
host_addr_in  input  6  host write address
host_data_in  input  16  host write data
host_ready_out  output  1  host write accepted when valid & ready
env_valid_in  input  1  envelope write request
env_addr_in  input  6  envelope write address
env_data_in  input  16  envelope write data
env_ready_out  output  1  envelope write accepted when valid & ready
master_count_out  output  10  master counter to the datapath
addr_out  output  6  write address to the datapath
data_out  output  16  write data to the datapath
data_valid_out  output  1  one-cycle write strobe to the datapath

Behaviour:
- Reset, at the clock edge with reset_in = 1:
  - master_count_out = 0; addr_out = 0; data_out = 0; data_valid_out = 0.
  - FIFO flushed; env holding register cleared; round-robin pointer set to host.
  - Applies mid-operation as well: queued and pending writes are discarded, not emitted.
- Counter:
  - next_count = count + run_in, wrapping 1023 -> 0.
  - master_count_out is registered.
- Host path:
  - host_ready_out = !fifo_full. It is combinational from registered state only, with no dependency on host_valid_in.
  - A push occurs on valid & ready.
  - No bypass: a write accepted in cycle N can appear on data_valid_out at cycle N+2 at the earliest (FIFO write at edge N, grant in cycle N+1, output registered at edge N+1).
- Envelope path:
  - env_ready_out = !env_pending.
  - Accept on valid & ready, which sets env_pending.
  - env_pending clears on the edge where the envelope write is granted. env_ready_out returns high the following cycle; there is no same-cycle refill.
- Grant window:
  - A grant is permitted in a cycle only if next_count[9:4] != 0.
  - With run_in = 1, grants are blocked while count is 1023 or 0..14.
  - With run_in = 0 and count in 0..15, grants are blocked indefinitely.
- Arbitration:
  - At most one grant per cycle.
  - If exactly one source is pending, it is granted.
  - If both are pending, the source at the pointer is granted, and the pointer then moves to the other source. A single-source grant also moves the pointer away from the granted source.
- Output:
  - On a grant, addr_out/data_out are loaded and data_valid_out = 1 for exactly one cycle. This coincides with master_count_out = next_count, so it always falls outside the compute window.
  - With no grant, data_valid_out = 0 and addr_out/data_out hold their last values.
- Simultaneous host push and FIFO pop in the same cycle is legal. Occupancy is unchanged.
- FIFO full: host_ready_out = 0; no overwrite.
- FIFO empty: no pop.
- Addresses are forwarded unchecked. Decoding of unmapped addresses is the datapath's job.

Decomposition:
- Shared package tone_gen_pkg holds:
  - the address map constants: PHASE_INCR_BASE 6'h00, VOLUME_BASE 6'h04, WAVE_TYPE_BASE 6'h08, WAVE_MEM_BASE 6'h20;
  - COUNT_WIDTH, ADDR_WIDTH, DATA_WIDTH;
  - the compute-window master_id constant 6'h00.
- One sub-module: param_fifo, a synchronous FIFO of {addr, data} with full/empty flags, push/pop, and synchronous active-high reset.

Test Plan:
- Reset, then run_in = 1 for 1100 cycles -> master_count_out steps 0, 1, ... 1023, 0; it holds when run_in = 0; no data_valid_out pulses.
- Host write {0x01, 0x1234} accepted at count = 100 -> data_valid_out = 1 at count = 102 with addr_out = 0x01 and data_out = 0x1234, for exactly 1 cycle.
- Host write accepted at count = 1020 -> strobe at count 1022; no strobe at counts 0..15. A write accepted at count 1022 strobes at count 16.
- 5 host writes pushed back-to-back while blocked (count = 0) -> ready drops after 4. After the window opens, the 4 writes emerge in order on consecutive cycles.
- Host FIFO and env both pending at count 200 -> host first, env next cycle, then alternating. env_ready_out returns high one cycle after the env grant.
- Reset asserted with 3 queued writes -> no strobes afterwards; host_ready_out = 1 and env_ready_out = 1 the cycle after reset is released.
